// File: rtl/axi_wdata_upsizer_if.sv
// ---------------------------------------------------------------------------
// axi_wdata_upsizer_if
// Write-data channel bundle for axi_wdata_upsizer: the narrow W input side,
// the burst start lane from the address path, and the wide W output side.
//   slave  : upsizer view (consumes s_*, produces m_*)
//   master : environment view (produces s_*, consumes m_*)
// Parameters must match those of the connected axi_wdata_upsizer.
// ---------------------------------------------------------------------------
interface axi_wdata_upsizer_if #(
    parameter int NARROW_W = 32,
    parameter int WIDE_W   = 128,
    parameter int LANE_W   = $clog2(WIDE_W / NARROW_W)
);
    logic [NARROW_W-1:0]   s_wdata;
    logic [NARROW_W/8-1:0] s_wstrb;
    logic                  s_wlast;
    logic                  s_wvalid;
    logic                  s_wready;
    logic [LANE_W-1:0]     s_start_lane;
    logic [WIDE_W-1:0]     m_wdata;
    logic [WIDE_W/8-1:0]   m_wstrb;
    logic                  m_wlast;
    logic                  m_wvalid;
    logic                  m_wready;

    modport slave (
        input  s_wdata, s_wstrb, s_wlast, s_wvalid, s_start_lane, m_wready,
        output s_wready, m_wdata, m_wstrb, m_wlast, m_wvalid
    );

    modport master (
        output s_wdata, s_wstrb, s_wlast, s_wvalid, s_start_lane, m_wready,
        input  s_wready, m_wdata, m_wstrb, m_wlast, m_wvalid
    );
endinterface

// File: rtl/axi_wdata_upsizer.sv
// ---------------------------------------------------------------------------
// axi_wdata_upsizer
// Packs narrow AXI W beats into wide W beats (ratio WIDE_W/NARROW_W, a power
// of two 2..16). Each burst starts at s_start_lane and continues through
// consecutive lanes, wrapping into the next wide beat. A wide beat is emitted
// when the top lane is filled or the narrow beat carries s_wlast; lanes that
// were not written carry data 0 and strb 0.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : axi_wdata_upsizer_if.slave (narrow W in, start lane, wide W out)
//   stat_wide_beats / stat_partial_beats : saturating 16-bit transfer
//              counters, present only when AXI_WDATA_UPSIZER_STATS_EN is
//              defined
// ---------------------------------------------------------------------------
module axi_wdata_upsizer #(
    parameter int NARROW_W = 32,
    parameter int WIDE_W   = 128,
    parameter int LANE_W   = $clog2(WIDE_W / NARROW_W)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    axi_wdata_upsizer_if.slave      bus
`ifdef AXI_WDATA_UPSIZER_STATS_EN
    ,
    output logic [15:0]             stat_wide_beats,
    output logic [15:0]             stat_partial_beats
`endif
);
    localparam int RATIO = WIDE_W / NARROW_W;
    localparam int NS_W  = NARROW_W / 8;

    logic [WIDE_W-1:0]   acc_data;
    logic [WIDE_W/8-1:0] acc_strb;
    logic [LANE_W-1:0]   lane_ptr;
    logic                first_beat;

    logic [WIDE_W-1:0]   out_data;
    logic [WIDE_W/8-1:0] out_strb;
    logic                out_last;
    logic                out_valid;

    logic [LANE_W-1:0]   lane;
    logic                accept;
    logic                complete;
    logic [WIDE_W-1:0]   merged_data;
    logic [WIDE_W/8-1:0] merged_strb;

    assign bus.s_wready = !out_valid || bus.m_wready;
    assign bus.m_wdata  = out_data;
    assign bus.m_wstrb  = out_strb;
    assign bus.m_wlast  = out_last;
    assign bus.m_wvalid = out_valid;

    assign lane     = first_beat ? bus.s_start_lane : lane_ptr;
    assign accept   = bus.s_wvalid && bus.s_wready;
    assign complete = (lane == LANE_W'(RATIO - 1)) || bus.s_wlast;

    // Accumulator with the incoming beat dropped into its lane.
    always_comb begin
        merged_data = acc_data;
        merged_strb = acc_strb;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (lane == LANE_W'(i)) begin
                merged_data[i*NARROW_W +: NARROW_W] = bus.s_wdata;
                merged_strb[i*NS_W +: NS_W]         = bus.s_wstrb;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_data   <= '0;
            acc_strb   <= '0;
            lane_ptr   <= '0;
            first_beat <= 1'b1;
            out_data   <= '0;
            out_strb   <= '0;
            out_last   <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            // A completing accept below overrides this, giving bubble-free reload.
            if (out_valid && bus.m_wready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (complete) begin
                    out_data   <= merged_data;
                    out_strb   <= merged_strb;
                    out_last   <= bus.s_wlast;
                    out_valid  <= 1'b1;
                    acc_data   <= '0;
                    acc_strb   <= '0;
                    lane_ptr   <= '0;
                    first_beat <= bus.s_wlast;
                end else begin
                    acc_data   <= merged_data;
                    acc_strb   <= merged_strb;
                    lane_ptr   <= lane + 1'b1;
                    first_beat <= 1'b0;
                end
            end
        end
    end

`ifdef AXI_WDATA_UPSIZER_STATS_EN
    logic wide_xfer;
    assign wide_xfer = out_valid && bus.m_wready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_wide_beats    <= '0;
            stat_partial_beats <= '0;
        end else if (wide_xfer) begin
            if (stat_wide_beats != '1) begin
                stat_wide_beats <= stat_wide_beats + 1'b1;
            end
            if (out_strb != '1 && stat_partial_beats != '1) begin
                stat_partial_beats <= stat_partial_beats + 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_axi_wdata_upsizer.sv
// ---------------------------------------------------------------------------
// tb_axi_wdata_upsizer
// Self-checking bench for axi_wdata_upsizer (NARROW_W=32, WIDE_W=128).
// Narrow beats come from a table of records; each record that should close a
// wide beat pushes the expected wide beat into a scoreboard queue, and a
// monitor pops and compares on every wide handshake. Backpressure, reset and
// (with AXI_WDATA_UPSIZER_STATS_EN) counter saturation are hand sequences.
// ---------------------------------------------------------------------------
module tb_axi_wdata_upsizer;
    logic clk;
    logic reset_n;

    axi_wdata_upsizer_if #(.NARROW_W(32), .WIDE_W(128)) bus ();

`ifdef AXI_WDATA_UPSIZER_STATS_EN
    logic [15:0] stat_wide_beats;
    logic [15:0] stat_partial_beats;
    int          mdl_wide;
    int          mdl_partial;
`endif

    axi_wdata_upsizer #(.NARROW_W(32), .WIDE_W(128)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef AXI_WDATA_UPSIZER_STATS_EN
        ,
        .stat_wide_beats    (stat_wide_beats),
        .stat_partial_beats (stat_partial_beats)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   lane;
        logic [31:0]  data;
        logic [3:0]   strb;
        logic         last;
        logic         emit;
        logic [127:0] exp_data;
        logic [15:0]  exp_strb;
        logic         exp_last;
    } vec_t;

    typedef struct {
        logic [127:0] data;
        logic [15:0]  strb;
        logic         last;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [127:0] d, input logic [15:0] s, input logic l);
        exp_t e;
        e.data = d;
        e.strb = s;
        e.last = l;
        sb.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send_beat(input logic [1:0] lane, input logic [31:0] d,
                             input logic [3:0] s, input logic l);
        bus.s_start_lane = lane;
        bus.s_wdata      = d;
        bus.s_wstrb      = s;
        bus.s_wlast      = l;
        bus.s_wvalid     = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (bus.s_wready) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL send_timeout actual=no_accept expected=accept data=%h", d);
    endtask

    // Scoreboard monitor: a handshake seen at negedge completes at the next posedge.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
`ifdef AXI_WDATA_UPSIZER_STATS_EN
            mdl_wide    = 0;
            mdl_partial = 0;
`endif
        end else if (bus.m_wvalid && bus.m_wready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=%h expected=none", bus.m_wdata);
            end else begin
                e = sb.pop_front();
                chk("sb_wdata", bus.m_wdata, e.data);
                chk("sb_wstrb", 128'(bus.m_wstrb), 128'(e.strb));
                chk("sb_wlast", 128'(bus.m_wlast), 128'(e.last));
`ifdef AXI_WDATA_UPSIZER_STATS_EN
                mdl_wide++;
                if (e.strb != 16'hFFFF) mdl_partial++;
`endif
            end
        end
    end

`ifdef AXI_WDATA_UPSIZER_STATS_EN
    task automatic chk_stats(input string tag);
        int ew;
        int ep;
        ew = (mdl_wide > 65535) ? 65535 : mdl_wide;
        ep = (mdl_partial > 65535) ? 65535 : mdl_partial;
        chk({"stat_wide_", tag}, 128'(stat_wide_beats), 128'(ew));
        chk({"stat_partial_", tag}, 128'(stat_partial_beats), 128'(ep));
    endtask
`endif

    vec_t vecs[14];

    initial begin
        logic [127:0] held;
        int           nv;

        // Table: lane0 full burst; start lane 2 with mid-burst lane changes
        // ignored; single beat at lane 3 then lane 1; zero strobe; wrap.
        vecs[0]  = '{2'd0, 32'h11110000, 4'hF, 1'b0, 1'b0, 128'h0, 16'h0, 1'b0};
        vecs[1]  = '{2'd0, 32'h11110001, 4'hF, 1'b0, 1'b0, 128'h0, 16'h0, 1'b0};
        vecs[2]  = '{2'd0, 32'h11110002, 4'hF, 1'b0, 1'b0, 128'h0, 16'h0, 1'b0};
        vecs[3]  = '{2'd0, 32'h11110003, 4'hF, 1'b1, 1'b1,
                     {32'h11110003, 32'h11110002, 32'h11110001, 32'h11110000}, 16'hFFFF, 1'b1};
        vecs[4]  = '{2'd2, 32'h2222000A, 4'hF, 1'b0, 1'b0, 128'h0, 16'h0, 1'b0};
        vecs[5]  = '{2'd1, 32'h2222000B, 4'hF, 1'b0, 1'b1,
                     {32'h2222000B, 32'h2222000A, 64'h0}, 16'hFF00, 1'b0};
        vecs[6]  = '{2'd3, 32'h2222000C, 4'hF, 1'b1, 1'b1,
                     {96'h0, 32'h2222000C}, 16'h000F, 1'b1};
        vecs[7]  = '{2'd3, 32'h33330001, 4'h3, 1'b1, 1'b1,
                     {32'h33330001, 96'h0}, 16'h3000, 1'b1};
        vecs[8]  = '{2'd1, 32'h33330002, 4'hF, 1'b1, 1'b1,
                     {64'h0, 32'h33330002, 32'h0}, 16'h00F0, 1'b1};
        vecs[9]  = '{2'd0, 32'h44440001, 4'h0, 1'b0, 1'b0, 128'h0, 16'h0, 1'b0};
        vecs[10] = '{2'd2, 32'h44440002, 4'hF, 1'b1, 1'b1,
                     {64'h0, 32'h44440002, 32'h44440001}, 16'h00F0, 1'b1};
        vecs[11] = '{2'd3, 32'h55550001, 4'hF, 1'b0, 1'b1,
                     {32'h55550001, 96'h0}, 16'hF000, 1'b0};
        vecs[12] = '{2'd2, 32'h55550002, 4'hF, 1'b0, 1'b0, 128'h0, 16'h0, 1'b0};
        vecs[13] = '{2'd1, 32'h55550003, 4'hF, 1'b1, 1'b1,
                     {64'h0, 32'h55550003, 32'h55550002}, 16'h00FF, 1'b1};
        nv = 14;

        reset_n          = 1'b0;
        bus.s_wdata      = '0;
        bus.s_wstrb      = '0;
        bus.s_wlast      = 1'b0;
        bus.s_wvalid     = 1'b0;
        bus.s_start_lane = '0;
        bus.m_wready     = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_wvalid", 128'(bus.m_wvalid), 128'h0);
        chk("rst_wdata", bus.m_wdata, 128'h0);
        chk("rst_wstrb", 128'(bus.m_wstrb), 128'h0);
        chk("rst_wlast", 128'(bus.m_wlast), 128'h0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_swready", 128'(bus.s_wready), 128'h1);

        // Table-driven bursts, m_wready held high.
        for (int i = 0; i < nv; i++) begin
            if (vecs[i].emit) push_exp(vecs[i].exp_data, vecs[i].exp_strb, vecs[i].exp_last);
            send_beat(vecs[i].lane, vecs[i].data, vecs[i].strb, vecs[i].last);
            if (vecs[i].emit) begin
                chk("lat_wvalid", 128'(bus.m_wvalid), 128'h1);
                chk("lat_wlast", 128'(bus.m_wlast), 128'(vecs[i].exp_last));
            end
        end
        bus.s_wvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // 8-beat burst with the first wide beat stalled for 5 cycles.
        push_exp({32'h66660003, 32'h66660002, 32'h66660001, 32'h66660000}, 16'hFFFF, 1'b0);
        push_exp({32'h66660007, 32'h66660006, 32'h66660005, 32'h66660004}, 16'hFFFF, 1'b1);
        bus.m_wready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send_beat(2'd0, 32'h66660000 + 32'(i), 4'hF, (i == 7));
                bus.s_wvalid = 1'b0;
            end
            begin
                int t;
                t = 0;
                @(negedge clk);
                while (!bus.m_wvalid && t < 50) begin
                    @(negedge clk);
                    t++;
                end
                chk("bp_wvalid_seen", 128'(bus.m_wvalid), 128'h1);
                held = bus.m_wdata;
                for (int c = 0; c < 5; c++) begin
                    if (c > 0) @(negedge clk);
                    chk("bp_swready", 128'(bus.s_wready), 128'h0);
                    chk("bp_wvalid", 128'(bus.m_wvalid), 128'h1);
                    chk("bp_wdata", bus.m_wdata, held);
                end
                @(posedge clk);
                #1 bus.m_wready = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 128'(sb.size()), 128'h0);
`ifdef AXI_WDATA_UPSIZER_STATS_EN
        chk_stats("pre_reset");
`endif

        // Reset after 2 of 4 beats; m_wdata still holds the previous wide beat.
        send_beat(2'd0, 32'h77770000, 4'hF, 1'b0);
        send_beat(2'd0, 32'h77770001, 4'hF, 1'b0);
        bus.s_wvalid = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_wvalid", 128'(bus.m_wvalid), 128'h0);
        chk("arst_wdata", bus.m_wdata, 128'h0);
        chk("arst_wstrb", 128'(bus.m_wstrb), 128'h0);
        chk("arst_wlast", 128'(bus.m_wlast), 128'h0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        push_exp({64'h0, 32'h88880001, 32'h88880000}, 16'h00FF, 1'b1);
        send_beat(2'd0, 32'h88880000, 4'hF, 1'b0);
        send_beat(2'd2, 32'h88880001, 4'hF, 1'b1);
        bus.s_wvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained_post_reset", 128'(sb.size()), 128'h0);

`ifdef AXI_WDATA_UPSIZER_STATS_EN
        chk_stats("post_reset");
        for (int i = 0; i < 65540; i++) begin
            push_exp({32'h9999AAAA, 96'h0}, 16'hF000, 1'b1);
            send_beat(2'd3, 32'h9999AAAA, 4'hF, 1'b1);
        end
        bus.s_wvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("stat_wide_sat", 128'(stat_wide_beats), 128'hFFFF);
        chk("stat_partial_sat", 128'(stat_partial_beats), 128'hFFFF);
        chk_stats("sat");
        chk("sb_drained_sat", 128'(sb.size()), 128'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
